// File: rtl/sd_init_ctrl_if.sv
// Command bus between the SD init sequencer and the single-command SPI engine.
interface sd_init_ctrl_if;
  logic [6:0]  cmd;
  logic [31:0] idata;
  logic        cmd_en;
  logic        cmd_rdy;
  logic        cmd_valid_status;
  logic [6:0]  cmd_resp_status;
  logic        data_valid;

  modport master (
    output cmd, idata, cmd_en,
    input  cmd_rdy, cmd_valid_status, cmd_resp_status, data_valid
  );

  modport slave (
    input  cmd, idata, cmd_en,
    output cmd_rdy, cmd_valid_status, cmd_resp_status, data_valid
  );
endinterface

// File: rtl/sd_init_ctrl.sv
// SD-card SPI-mode sequencer: power-up clocks, CMD0, CMD1 polling, then
// CMD17 single-block reads, driving the spi_cmd engine over sd_init_ctrl_if.
module sd_init_ctrl #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned INIT_CLKS  = 80,
  parameter int unsigned CMD0_RETRY = 8,
  parameter int unsigned CMD1_RETRY = 1000,
  parameter int unsigned GAP_CLKS   = 8,
  parameter int unsigned TIMEOUT    = 65535
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          rd_req,
  input  logic [31:0]   rd_addr,
  output logic          rd_ack,
  output logic          rd_done,
  output logic          init_done,
  output logic          busy,
  output logic          err,
  output logic [1:0]    err_code,
  sd_init_ctrl_if.master eng,
  output logic          sclk,
  output logic          cs_n
);

  localparam int unsigned DIV_W    = $clog2(CLK_DIV);
  localparam int unsigned EDGE_MAX = (INIT_CLKS > GAP_CLKS) ? INIT_CLKS : GAP_CLKS;
  localparam int unsigned EDGE_W   = $clog2(EDGE_MAX + 1);
  localparam int unsigned A0_W     = $clog2(CMD0_RETRY + 1);
  localparam int unsigned A1_W     = $clog2(CMD1_RETRY + 1);
  localparam int unsigned WD_W     = $clog2(TIMEOUT + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_INIT = EDGE_W'(INIT_CLKS);
  localparam logic [EDGE_W-1:0] EDGE_GAP  = EDGE_W'(GAP_CLKS);
  localparam logic [A0_W-1:0]   A0_LAST   = A0_W'(CMD0_RETRY - 1);
  localparam logic [A0_W-1:0]   A0_MAX    = A0_W'(CMD0_RETRY);
  localparam logic [A1_W-1:0]   A1_LAST   = A1_W'(CMD1_RETRY - 1);
  localparam logic [A1_W-1:0]   A1_MAX    = A1_W'(CMD1_RETRY);
  localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PWRUP = 3'd1;
  localparam logic [2:0] S_CMD0  = 3'd2;
  localparam logic [2:0] S_CMD1  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;
  localparam logic [2:0] S_READY = 3'd5;
  localparam logic [2:0] S_READ  = 3'd6;
  localparam logic [2:0] S_ERROR = 3'd7;

  logic [2:0]        state, state_nxt, gap_ret;
  logic [1:0]        code_nxt;
  logic [DIV_W-1:0]  div_cnt;
  logic [EDGE_W-1:0] edge_cnt;
  logic [A0_W-1:0]   att0;
  logic [A1_W-1:0]   att1;
  logic [WD_W-1:0]   wdog;
  logic [6:0]        r1;
  logic              r1_got;
  logic [9:0]        dcnt;
  logic              rdy_q;

  logic ent, run_nxt, sclk_rise, cmd_done, rd_fin, tmo;

  assign ent       = (state_nxt != state);
  // sclk runs in every state that is not parked (IDLE, READY, ERROR)
  assign run_nxt   = !(state_nxt == S_IDLE || state_nxt == S_READY || state_nxt == S_ERROR);
  assign sclk_rise = run_nxt && (div_cnt == DIV_LAST) && !sclk;
  assign cmd_done  = eng.cmd_en && r1_got && eng.cmd_rdy;
  assign rd_fin    = eng.cmd_en && eng.cmd_rdy && !rdy_q;
  assign tmo       = eng.cmd_en && (wdog == WD_LAST);

  // Next-state and error-code selection; timeout outranks completion
  always_comb begin
    state_nxt = state;
    code_nxt  = err_code;
    case (state)
      S_IDLE:  if (start) state_nxt = S_PWRUP;
      S_PWRUP: if (edge_cnt == EDGE_INIT) state_nxt = S_CMD0;
      S_CMD0: begin
        if (tmo) begin
          state_nxt = S_ERROR;
          code_nxt  = 2'd3;
        end else if (cmd_done) begin
          if (r1 == 7'h01)         state_nxt = S_CMD1;
          else if (att0 < A0_LAST) state_nxt = S_GAP;
          else begin
            state_nxt = S_ERROR;
            code_nxt  = 2'd1;
          end
        end
      end
      S_CMD1: begin
        if (tmo) begin
          state_nxt = S_ERROR;
          code_nxt  = 2'd3;
        end else if (cmd_done) begin
          if (r1 == 7'h00)                          state_nxt = S_READY;
          else if (r1 == 7'h01 && att1 < A1_LAST)  state_nxt = S_GAP;
          else begin
            state_nxt = S_ERROR;
            code_nxt  = 2'd2;
          end
        end
      end
      S_GAP:   if (edge_cnt == EDGE_GAP) state_nxt = gap_ret;
      S_READY: if (rd_req) state_nxt = S_READ;
      S_READ: begin
        if (tmo) begin
          state_nxt = S_ERROR;
          code_nxt  = 2'd3;
        end else if (rd_fin) begin
          if (dcnt == 10'd512 && !(r1_got && r1 != 7'h00)) state_nxt = S_READY;
          else begin
            state_nxt = S_ERROR;
            code_nxt  = 2'd3;
          end
        end
      end
      S_ERROR: if (start) begin
        state_nxt = S_PWRUP;
        code_nxt  = 2'd0;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, counters and registered outputs; outputs follow the next state so
  // they change on the same edge as the state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      gap_ret   <= S_IDLE;
      err_code  <= '0;
      div_cnt   <= '0;
      edge_cnt  <= '0;
      att0      <= '0;
      att1      <= '0;
      wdog      <= '0;
      r1        <= '0;
      r1_got    <= 1'b0;
      dcnt      <= '0;
      rdy_q     <= 1'b0;
      sclk      <= 1'b1;
      cs_n      <= 1'b1;
      eng.cmd_en <= 1'b0;
      eng.cmd   <= '0;
      eng.idata <= '0;
      rd_ack    <= 1'b0;
      rd_done   <= 1'b0;
      init_done <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state    <= state_nxt;
      err_code <= code_nxt;
      rdy_q    <= eng.cmd_rdy;
      if (ent && state_nxt == S_GAP) gap_ret <= state;

      if (!run_nxt) begin
        sclk    <= 1'b1;
        div_cnt <= '0;
      end else if (div_cnt == DIV_LAST) begin
        sclk    <= ~sclk;
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end

      if (ent)            edge_cnt <= '0;
      else if (sclk_rise) edge_cnt <= edge_cnt + 1'b1;

      if (ent)             wdog <= '0;
      else if (eng.cmd_en) wdog <= wdog + 1'b1;

      if (ent) begin
        r1     <= '0;
        r1_got <= 1'b0;
      end else if (eng.cmd_en && eng.cmd_valid_status) begin
        r1     <= eng.cmd_resp_status;
        r1_got <= 1'b1;
      end

      if (ent)                                  dcnt <= '0;
      else if (state == S_READ && eng.data_valid) dcnt <= dcnt + 1'b1;

      if (state_nxt == S_PWRUP && ent) begin
        att0 <= '0;
        att1 <= '0;
      end else if (state == S_CMD0 && cmd_done && !tmo) begin
        if (att0 != A0_MAX) att0 <= att0 + 1'b1;
        if (state_nxt == S_CMD1) att1 <= '0;
      end else if (state == S_CMD1 && cmd_done && !tmo) begin
        if (att1 != A1_MAX) att1 <= att1 + 1'b1;
      end

      eng.cmd_en <= !ent && (state == S_CMD0 || state == S_CMD1 || state == S_READ);
      case (state_nxt)
        S_CMD0:  eng.cmd <= 7'd0;
        S_CMD1:  eng.cmd <= 7'd1;
        S_READ:  eng.cmd <= 7'd17;
        default: ;
      endcase
      if (state == S_READY && state_nxt == S_READ)      eng.idata <= rd_addr;
      else if (state_nxt == S_CMD0 || state_nxt == S_CMD1) eng.idata <= '0;

      cs_n      <= (state_nxt == S_IDLE || state_nxt == S_PWRUP || state_nxt == S_ERROR);
      rd_ack    <= (state == S_READY) && (state_nxt == S_READ);
      rd_done   <= (state == S_READ) && ent;
      init_done <= (state_nxt == S_READY || state_nxt == S_READ);
      busy      <= run_nxt;
      err       <= (state_nxt == S_ERROR);
    end
  end

endmodule

// File: tb/tb_sd_init_ctrl.sv
// Directed bench for sd_init_ctrl: init, CMD0 exhaustion, reads, timeout, reset.
module tb_sd_init_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start = 1'b0, rd_req = 1'b0;
  logic [31:0] rd_addr = '0;
  logic        rd_ack, rd_done, init_done, busy, err, sclk, cs_n;
  logic [1:0]  err_code;
  sd_init_ctrl_if ifc ();

  logic        t_start = 1'b0, t_rd_req = 1'b0;
  logic [31:0] t_rd_addr = '0;
  logic        t_rd_ack, t_rd_done, t_init_done, t_busy, t_err, t_sclk, t_cs_n;
  logic [1:0]  t_err_code;
  sd_init_ctrl_if ifc_t ();

  sd_init_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_ack(rd_ack), .rd_done(rd_done), .init_done(init_done), .busy(busy),
    .err(err), .err_code(err_code), .eng(ifc), .sclk(sclk), .cs_n(cs_n)
  );

  sd_init_ctrl #(.TIMEOUT(200)) dut_t (
    .clk(clk), .rst_n(rst_n), .start(t_start), .rd_req(t_rd_req), .rd_addr(t_rd_addr),
    .rd_ack(t_rd_ack), .rd_done(t_rd_done), .init_done(t_init_done), .busy(t_busy),
    .err(t_err), .err_code(t_err_code), .eng(ifc_t), .sclk(t_sclk), .cs_n(t_cs_n)
  );

  int total = 0;
  int bad = 0;

  int   rise_hi = 0, ack_cnt = 0, done_cnt = 0;
  logic sclk_prev = 1'b1;
  always @(negedge clk) begin
    if (sclk && !sclk_prev && cs_n) rise_hi++;
    sclk_prev = sclk;
    if (rd_ack)  ack_cnt++;
    if (rd_done) done_cnt++;
  end

  bit          sv_got, sv_stable;
  logic [6:0]  sv_cmd;
  logic [31:0] sv_addr;

  task automatic tick();
    @(negedge clk);
    if (ifc.cmd_en === 1'b1 && (ifc.cmd !== sv_cmd || ifc.idata !== sv_addr || cs_n !== 1'b0))
      sv_stable = 0;
  endtask

  // Engine model: waits for cmd_en, returns R1 and nbytes data strobes, then raises cmd_rdy
  task automatic serve_cmd(input logic [6:0] resp, input int nbytes);
    int n = 0;
    sv_got = 0; sv_stable = 1; sv_cmd = '0; sv_addr = '0;
    while (ifc.cmd_en !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    if (ifc.cmd_en !== 1'b1) return;
    sv_cmd = ifc.cmd; sv_addr = ifc.idata;
    if (cs_n !== 1'b0) sv_stable = 0;
    ifc.cmd_rdy = 1'b0;
    repeat (3) tick();
    ifc.cmd_resp_status = resp; ifc.cmd_valid_status = 1'b1;
    tick();
    ifc.cmd_valid_status = 1'b0;
    for (int i = 0; i < nbytes; i++) begin ifc.data_valid = 1'b1; tick(); end
    ifc.data_valid = 1'b0;
    tick();
    ifc.cmd_rdy = 1'b1;
    n = 0;
    do begin tick(); n++; end while (ifc.cmd_en === 1'b1 && n < 100);
    sv_got = (ifc.cmd_en === 1'b0);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++; if (sclk !== 1'b1)      begin bad++; $display("FAIL rst_sclk got=%b want=1", sclk); end
    total++; if (cs_n !== 1'b1)      begin bad++; $display("FAIL rst_cs_n got=%b want=1", cs_n); end
    total++; if (ifc.cmd_en !== 1'b0) begin bad++; $display("FAIL rst_cmd_en got=%b want=0", ifc.cmd_en); end
    total++; if (ifc.cmd !== 7'd0)   begin bad++; $display("FAIL rst_cmd got=%h want=0", ifc.cmd); end
    total++; if (ifc.idata !== 32'd0) begin bad++; $display("FAIL rst_idata got=%h want=0", ifc.idata); end
    total++; if ({rd_ack, rd_done, init_done, busy, err} !== 5'b0)
      begin bad++; $display("FAIL rst_flags got=%b want=00000", {rd_ack, rd_done, init_done, busy, err}); end
    total++; if (err_code !== 2'd0)  begin bad++; $display("FAIL rst_err_code got=%0d want=0", err_code); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    total++; if (busy !== 1'b0 || sclk !== 1'b1) begin bad++; $display("FAIL idle_hold busy=%b sclk=%b want 0/1", busy, sclk); end
  endtask

  task automatic test_init();
    int r0, n1;
    logic [6:0] rs [3];
    rs[0] = 7'h01; rs[1] = 7'h01; rs[2] = 7'h00;
    r0 = rise_hi;
    start = 1'b1; @(negedge clk); start = 1'b0;
    serve_cmd(7'h01, 0);
    total++; if (!sv_got || sv_cmd !== 7'd0 || sv_addr !== 32'd0 || !sv_stable)
      begin bad++; $display("FAIL init_cmd0 got=%b cmd=%0d arg=%h stable=%b want 1/0/0/1", sv_got, sv_cmd, sv_addr, sv_stable); end
    n1 = 0;
    for (int i = 0; i < 3; i++) begin
      serve_cmd(rs[i], 0);
      if (sv_got && sv_cmd === 7'd1 && sv_stable) n1++;
    end
    repeat (2) @(negedge clk);
    total++; if (rise_hi - r0 != 80) begin bad++; $display("FAIL init_rises got=%0d want=80", rise_hi - r0); end
    total++; if (n1 != 3) begin bad++; $display("FAIL init_cmd1_count got=%0d want=3", n1); end
    total++; if (init_done !== 1'b1 || err !== 1'b0 || busy !== 1'b0)
      begin bad++; $display("FAIL init_ready init_done=%b err=%b busy=%b want 1/0/0", init_done, err, busy); end
    total++; if (cs_n !== 1'b0 || sclk !== 1'b1) begin bad++; $display("FAIL ready_pins cs_n=%b sclk=%b want 0/1", cs_n, sclk); end
  endtask

  task automatic test_read_ok();
    int a0, d0, n;
    a0 = ack_cnt; d0 = done_cnt;
    rd_addr = 32'h0000_1234; rd_req = 1'b1;
    n = 0;
    while (rd_ack !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    rd_req = 1'b0; rd_addr = 32'hDEAD_BEEF;
    serve_cmd(7'h00, 512);
    total++; if (!sv_got || sv_cmd !== 7'd17 || sv_addr !== 32'h0000_1234 || !sv_stable)
      begin bad++; $display("FAIL read_cmd got=%b cmd=%0d arg=%h stable=%b want 1/17/00001234/1", sv_got, sv_cmd, sv_addr, sv_stable); end
    total++; if (rd_done !== 1'b1 || err !== 1'b0) begin bad++; $display("FAIL read_done rd_done=%b err=%b want 1/0", rd_done, err); end
    repeat (3) @(negedge clk);
    total++; if (ack_cnt - a0 != 1 || done_cnt - d0 != 1)
      begin bad++; $display("FAIL read_pulses ack=%0d done=%0d want 1/1", ack_cnt - a0, done_cnt - d0); end
    total++; if (init_done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL read_back_ready init_done=%b busy=%b want 1/0", init_done, busy); end
  endtask

  task automatic test_read_short();
    int n;
    rd_addr = 32'h0000_0042; rd_req = 1'b1;
    n = 0;
    while (rd_ack !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    rd_req = 1'b0;
    serve_cmd(7'h00, 511);
    total++; if (!sv_got || rd_done !== 1'b1 || err !== 1'b1 || err_code !== 2'd3)
      begin bad++; $display("FAIL short_err got=%b rd_done=%b err=%b code=%0d want 1/1/1/3", sv_got, rd_done, err, err_code); end
    start = 1'b1; @(negedge clk); start = 1'b0;
    serve_cmd(7'h01, 0);
    serve_cmd(7'h00, 0);
    repeat (2) @(negedge clk);
    total++; if (init_done !== 1'b1 || err !== 1'b0 || err_code !== 2'd0)
      begin bad++; $display("FAIL reinit init_done=%b err=%b code=%0d want 1/0/0", init_done, err, err_code); end
  endtask

  task automatic test_reset_mid_read();
    int a0, n;
    rd_addr = 32'h0000_0777; rd_req = 1'b1;
    n = 0;
    while (ifc.cmd_en !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    ifc.cmd_rdy = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if (cs_n !== 1'b1 || ifc.cmd_en !== 1'b0 || sclk !== 1'b1)
      begin bad++; $display("FAIL async_rst cs_n=%b cmd_en=%b sclk=%b want 1/0/1", cs_n, ifc.cmd_en, sclk); end
    @(negedge clk); rst_n = 1'b1; ifc.cmd_rdy = 1'b1;
    a0 = ack_cnt;
    repeat (30) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    serve_cmd(7'h01, 0);
    serve_cmd(7'h00, 0);
    total++; if (ack_cnt != a0 || init_done !== 1'b1)
      begin bad++; $display("FAIL no_early_ack acks=%0d init_done=%b want 0/1", ack_cnt - a0, init_done); end
    n = 0;
    while (rd_ack !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    total++; if (rd_ack !== 1'b1) begin bad++; $display("FAIL ack_after_init got=%b want=1", rd_ack); end
    rd_req = 1'b0;
    serve_cmd(7'h00, 512);
    repeat (2) @(negedge clk);
    total++; if (init_done !== 1'b1 || err !== 1'b0) begin bad++; $display("FAIL post_rst_read init_done=%b err=%b want 1/0", init_done, err); end
  endtask

  task automatic test_cmd0_fail();
    int n0;
    bit all0;
    @(negedge clk); rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
    start = 1'b1; @(negedge clk); start = 1'b0;
    n0 = 0; all0 = 1;
    for (int i = 0; i < 10; i++) begin
      serve_cmd(7'h7F, 0);
      if (!sv_got) break;
      if (sv_cmd !== 7'd0) all0 = 0;
      n0++;
    end
    total++; if (n0 != 8 || !all0) begin bad++; $display("FAIL cmd0_issues got=%0d all_cmd0=%b want 8/1", n0, all0); end
    total++; if (err !== 1'b1 || err_code !== 2'd1) begin bad++; $display("FAIL cmd0_err err=%b code=%0d want 1/1", err, err_code); end
    total++; if (cs_n !== 1'b1 || sclk !== 1'b1 || busy !== 1'b0 || init_done !== 1'b0)
      begin bad++; $display("FAIL cmd0_pins cs_n=%b sclk=%b busy=%b init_done=%b want 1/1/0/0", cs_n, sclk, busy, init_done); end
  endtask

  task automatic test_timeout();
    int n, cnt;
    t_start = 1'b1; @(negedge clk); t_start = 1'b0;
    n = 0;
    while (ifc_t.cmd_en !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    total++; if (ifc_t.cmd_en !== 1'b1) begin bad++; $display("FAIL tmo_cmd_en_rise got=%b want=1", ifc_t.cmd_en); end
    cnt = 0; n = 0;
    while (t_err !== 1'b1 && n < 1000) begin
      if (ifc_t.cmd_en === 1'b1) cnt++;
      @(negedge clk); n++;
    end
    total++; if (cnt != 200) begin bad++; $display("FAIL tmo_cycles got=%0d want=200", cnt); end
    total++; if (t_err !== 1'b1 || t_err_code !== 2'd3 || ifc_t.cmd_en !== 1'b0 || t_cs_n !== 1'b1)
      begin bad++; $display("FAIL tmo_err err=%b code=%0d cmd_en=%b cs_n=%b want 1/3/0/1", t_err, t_err_code, ifc_t.cmd_en, t_cs_n); end
  endtask

  initial begin
    ifc.cmd_rdy = 1'b1; ifc.cmd_valid_status = 1'b0; ifc.cmd_resp_status = '0; ifc.data_valid = 1'b0;
    ifc_t.cmd_rdy = 1'b0; ifc_t.cmd_valid_status = 1'b0; ifc_t.cmd_resp_status = '0; ifc_t.data_valid = 1'b0;
    test_reset();
    test_init();
    test_read_ok();
    test_read_short();
    test_reset_mid_read();
    test_cmd0_fail();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
